// File: rtl/i2c_codec_target.sv
// I2C write-only target for the audio codec control port: decodes {reg, d8}, d[7:0]
// register writes addressed to DEV_ADDR and shadows them in a 9-bit register file.
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         NUM_REGS  = 16,
    parameter logic [6:0] RESET_REG = 7'h0F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_oe,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy,
    output logic [7:0] wr_count
);
    localparam int         AW          = $clog2(NUM_REGS);
    localparam logic [6:0] NUM_REGS_7  = 7'(NUM_REGS);
    localparam logic [7:0] WR_ADDR_BYTE = {DEV_ADDR, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_BYTE1, S_ACK_1, S_BYTE2, S_ACK_2, S_WAIT_STOP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_scl_s1, r_scl_s2, r_scl_d;
    logic        r_sda_s1, r_sda_s2, r_sda_d;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_oe;
    logic [6:0]  r_reg;
    logic        r_d8;
    logic [7:0]  r_data;
    logic        r_strobe;
    logic [6:0]  r_wr_addr;
    logic [8:0]  r_wr_data;
    logic [7:0]  r_wr_count;
    logic [8:0]  r_regs [NUM_REGS];

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_bit_done;
    logic w_shift_en, w_cnt_clr, w_oe_nxt, w_latch1, w_latch2, w_commit;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_bit_done = (r_bit_cnt == 4'd8);

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_cnt_clr   = 1'b0;
        w_oe_nxt    = r_oe;
        w_latch1    = 1'b0;
        w_latch2    = 1'b0;
        w_commit    = 1'b0;
        if (w_start) begin
            w_state_nxt = S_ADDR;
            w_cnt_clr   = 1'b1;
            w_oe_nxt    = 1'b0;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_oe_nxt    = 1'b0;
        end else begin
            // Data bits shift on SCL rise; the falling edge after bit 8 decides ACK/NACK.
            if ((r_state == S_ADDR || r_state == S_BYTE1 || r_state == S_BYTE2)
                && w_scl_rise && !w_bit_done) begin
                w_shift_en = 1'b1;
            end
            case (r_state)
                S_ADDR: if (w_scl_fall && w_bit_done) begin
                    if (r_shift == WR_ADDR_BYTE) begin
                        w_state_nxt = S_ACK_A;
                        w_oe_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT_STOP;
                    end
                end
                S_BYTE1: if (w_scl_fall && w_bit_done) begin
                    if (r_shift[7:1] < NUM_REGS_7) begin
                        w_state_nxt = S_ACK_1;
                        w_oe_nxt    = 1'b1;
                        w_latch1    = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT_STOP;
                    end
                end
                S_BYTE2: if (w_scl_fall && w_bit_done) begin
                    w_state_nxt = S_ACK_2;
                    w_oe_nxt    = 1'b1;
                    w_latch2    = 1'b1;
                end
                S_ACK_A: if (w_scl_fall) begin
                    w_state_nxt = S_BYTE1;
                    w_oe_nxt    = 1'b0;
                    w_cnt_clr   = 1'b1;
                end
                S_ACK_1: if (w_scl_fall) begin
                    w_state_nxt = S_BYTE2;
                    w_oe_nxt    = 1'b0;
                    w_cnt_clr   = 1'b1;
                end
                S_ACK_2: if (w_scl_fall) begin
                    w_state_nxt = S_WAIT_STOP;
                    w_oe_nxt    = 1'b0;
                    w_commit    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_scl_s1   <= 1'b1;
            r_scl_s2   <= 1'b1;
            r_scl_d    <= 1'b1;
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
            r_sda_d    <= 1'b1;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'd0;
            r_oe       <= 1'b0;
            r_reg      <= 7'd0;
            r_d8       <= 1'b0;
            r_data     <= 8'd0;
            r_strobe   <= 1'b0;
            r_wr_addr  <= 7'd0;
            r_wr_data  <= 9'd0;
            r_wr_count <= 8'd0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 9'd0;
        end else begin
            r_scl_s1 <= i2c_scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= i2c_sda_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
            r_state  <= w_state_nxt;
            r_oe     <= w_oe_nxt;
            r_strobe <= w_commit;
            if (w_cnt_clr) begin
                r_bit_cnt <= 4'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_shift   <= {r_shift[6:0], r_sda_s2};
            end
            if (w_latch1) begin
                r_reg <= r_shift[7:1];
                r_d8  <= r_shift[0];
            end
            if (w_latch2) r_data <= r_shift;
            if (w_commit) begin
                r_wr_addr <= r_reg;
                r_wr_data <= {r_d8, r_data};
                if (r_wr_count != 8'hFF) r_wr_count <= r_wr_count + 8'd1;
                if (r_reg == RESET_REG) begin
                    for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 9'd0;
                end else begin
                    r_regs[r_reg[AW-1:0]] <= {r_d8, r_data};
                end
            end
        end
    end

    assign i2c_sda_oe = r_oe;
    assign wr_strobe  = r_strobe;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign wr_count   = r_wr_count;
    assign busy       = (r_state != S_IDLE);
    assign rd_data    = r_regs[rd_addr];
endmodule

// File: tb/tb_i2c_codec_target.sv
// Bench for i2c_codec_target: bit-banged I2C master, transaction-level reference model
// of the codec register file, and a strobe scoreboard.
module tb_i2c_codec_target;
    localparam int Q = 10;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, sda_m;
    logic       i2c_sda_in;
    logic       i2c_sda_oe;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       busy;
    logic [7:0] wr_count;

    assign i2c_sda_in = sda_m & ~i2c_sda_oe;

    i2c_codec_target dut (
        .clk(clk), .reset(reset), .i2c_scl(scl_m), .i2c_sda_in(i2c_sda_in),
        .i2c_sda_oe(i2c_sda_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [8:0]  m_regs [16];
    int          m_count = 0;
    bit          oe_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (i2c_sda_oe) oe_seen = 1'b1;
        if (wr_strobe) begin
            check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[15:9]));
                check("wr_data", 32'(wr_data), 32'(e[8:0]));
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        @(negedge clk);
        ack = i2c_sda_oe;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    // Reference: commit happens only after a third ACKed byte; model applied at that point.
    task automatic model_commit(input logic [7:0] b1, input logic [7:0] b2);
        logic [6:0] r;
        r = b1[7:1];
        if (r == 7'h0F) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 9'd0;
        end else begin
            m_regs[r[3:0]] = {b1[0], b2};
        end
        if (m_count < 255) m_count++;
        exp_q.push_back({r, b1[0], b2});
    endtask

    task automatic write_bytes(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3, input int nbytes);
        logic [7:0] bytes [4];
        logic       ack;
        bit         a_ok, r_ok, exp_ack;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        a_ok = (b0 == 8'h34);
        r_ok = a_ok && (b1[7:1] < 7'd16);
        for (int k = 0; k < nbytes; k++) begin
            exp_ack = (k == 0) ? a_ok : (k <= 2) ? r_ok : 1'b0;
            if (k == 2 && r_ok) model_commit(b1, b2);
            send_byte(bytes[k], ack);
            check($sformatf("ack_byte%0d", k), 32'(ack), 32'(exp_ack));
        end
    endtask

    task automatic txn(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3, input int nbytes);
        i2c_start();
        write_bytes(b0, b1, b2, b3, nbytes);
        i2c_stop();
        @(negedge clk);
        check("busy_after_stop", 32'(busy), 32'd0);
        check("oe_after_stop", 32'(i2c_sda_oe), 32'd0);
        check("wr_count", 32'(wr_count), 32'(m_count));
        check("pending_strobes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_regs();
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            @(negedge clk);
            check($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(m_regs[i]));
        end
    endtask

    task automatic check_reg(input int i);
        rd_addr = 4'(i);
        @(negedge clk);
        check($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(m_regs[i]));
    endtask

    initial begin
        logic       ack;
        logic [7:0] b0, b1, b2, b3;
        logic [6:0] r;
        for (int i = 0; i < 16; i++) m_regs[i] = 9'd0;
        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rd_addr = 4'd0;
        wait_clk(5);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_oe", 32'(i2c_sda_oe), 32'd0);
        check("rst_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check_regs();

        // Basic write: reg 6 <= 0x007
        txn(8'h34, 8'h0C, 8'h07, 8'h00, 3);
        check_reg(6);

        // Foreign address: never drive SDA, busy until STOP
        oe_seen = 1'b0;
        i2c_start();
        write_bytes(8'h36, 8'h0C, 8'h55, 8'h00, 3);
        @(negedge clk);
        check("busy_foreign", 32'(busy), 32'd1);
        i2c_stop();
        @(negedge clk);
        check("oe_seen_foreign", 32'(oe_seen), 32'd0);
        check("busy_foreign_stop", 32'(busy), 32'd0);

        // Read request and out-of-range register
        txn(8'h35, 8'h0C, 8'h07, 8'h00, 2);
        txn(8'h34, 8'h20, 8'h5A, 8'h00, 3);
        check_regs();

        // Load reg 4 with 0x1FF, then clear via the reset register
        txn(8'h34, 8'h09, 8'hFF, 8'h00, 3);
        check_reg(4);
        txn(8'h34, 8'h1E, 8'h00, 8'h00, 4);
        check_regs();

        // STOP after 4 bits of byte2 commits nothing
        i2c_start();
        write_bytes(8'h34, 8'h0C, 8'h00, 8'h00, 2);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_stop();
        @(negedge clk);
        check("partial_count", 32'(wr_count), 32'(m_count));
        check("partial_busy", 32'(busy), 32'd0);

        // Repeated START abandons the first transfer
        i2c_start();
        write_bytes(8'h34, 8'h04, 8'h00, 8'h00, 2);
        txn(8'h34, 8'h05, 8'hA5, 8'h00, 3);
        check_regs();

        // Reset pulsed mid-BYTE1 aborts; then a valid write succeeds
        i2c_start();
        write_bytes(8'h34, 8'h00, 8'h00, 8'h00, 1);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_oe", 32'(i2c_sda_oe), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(wr_count), 32'd0);
        for (int i = 0; i < 16; i++) m_regs[i] = 9'd0;
        m_count = 0;
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        @(negedge clk);
        check("midrst_idle_busy", 32'(busy), 32'd0);
        txn(8'h34, 8'h15, 8'h3C, 8'h00, 3);
        check_regs();

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            b0 = ($urandom_range(0, 9) < 8) ? 8'h34 : 8'($urandom);
            r  = 7'($urandom_range(0, 19));
            if (r == 7'h0F && $urandom_range(0, 1) == 0) r = 7'h03;
            b1 = {r, 1'($urandom)};
            b2 = 8'($urandom);
            b3 = 8'($urandom);
            txn(b0, b1, b2, b3, $urandom_range(1, 4));
            check_reg($urandom_range(0, 15));
        end
        check_regs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
